// File: rtl/snax_hwpe_periph_regfile.sv
// Peripheral-bus target holding the accelerator job-configuration registers and
// the job trigger / status / done-count / soft-clear control.
module snax_hwpe_periph_regfile #(
   parameter int unsigned NumRegs = 16,
   parameter logic [31:0] RegBase = 32'h40,
   parameter int unsigned IdWidth = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    periph_req_i,
   output logic                    periph_gnt_o,
   input  logic [31:0]             periph_add_i,
   input  logic                    periph_wen_i,
   input  logic [3:0]              periph_be_i,
   input  logic [31:0]             periph_data_i,
   input  logic [IdWidth-1:0]      periph_id_i,
   output logic                    periph_r_valid_o,
   output logic [31:0]             periph_r_data_o,
   output logic [IdWidth-1:0]      periph_r_id_o,
   output logic [NumRegs*32-1:0]   reg_o,
   output logic                    start_o,
   output logic                    clear_o,
   output logic                    busy_o,
   input  logic                    done_i
);

   localparam int unsigned IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
   localparam logic [29:0] NumRegsW = 30'(NumRegs);

   typedef enum logic {IDLE, RESP} state_e;

   state_e               state_reg, state_next;
   logic [IdWidth-1:0]   resp_id_reg;
   logic [31:0]          resp_data_reg;
   logic                 busy_reg;
   logic                 err_reg;
   logic [31:0]          done_cnt_reg;
   logic                 start_reg;
   logic                 clear_reg;

   logic                 grant;
   logic [29:0]          word;
   logic [31:0]          cfg_off;
   logic                 cfg_hit;
   logic [IdxW-1:0]      cfg_idx;
   logic                 is_write;
   logic                 trig_wr;
   logic                 clr_wr;
   logic                 cfg_wr;
   logic                 job_done;
   logic [31:0]          rdata_mux;

   assign grant    = periph_req_i && (state_reg == IDLE);
   assign word     = periph_add_i[31:2];
   assign cfg_off  = {word, 2'b00} - RegBase;
   assign cfg_hit  = (word >= RegBase[31:2]) && (cfg_off[31:2] < NumRegsW);
   assign cfg_idx  = cfg_off[IdxW+1:2];
   assign is_write = grant && !periph_wen_i;
   assign trig_wr  = is_write && (word == 30'd0);
   assign clr_wr   = is_write && (word == 30'd2);
   // Config registers are locked while a job is running.
   assign cfg_wr   = is_write && cfg_hit && !busy_reg;
   assign job_done = done_i && busy_reg;

   always_comb begin
      rdata_mux = '0;
      if (cfg_hit) begin
         rdata_mux = reg_o[{cfg_idx, 5'b00000} +: 32];
      end else if (word == 30'd1) begin
         rdata_mux = {30'b0, err_reg, busy_reg};
      end else if (word == 30'd3) begin
         rdata_mux = done_cnt_reg;
      end
   end

   for (genvar gi = 0; gi < NumRegs; gi++) begin : g_cfg
      logic [31:0] cfg_reg;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cfg_reg <= '0;
         end else if (clr_wr) begin
            cfg_reg <= '0;
         end else if (cfg_wr && (cfg_idx == IdxW'(gi))) begin
            for (int b = 0; b < 4; b++) begin
               if (periph_be_i[b]) cfg_reg[8*b +: 8] <= periph_data_i[8*b +: 8];
            end
         end
      end
      assign reg_o[32*gi +: 32] = cfg_reg;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (grant) state_next = RESP;
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= IDLE;
         resp_id_reg   <= '0;
         resp_data_reg <= '0;
         busy_reg      <= 1'b0;
         err_reg       <= 1'b0;
         done_cnt_reg  <= '0;
         start_reg     <= 1'b0;
         clear_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (grant) begin
            resp_id_reg   <= periph_id_i;
            // Reads return the value seen before this edge's updates.
            resp_data_reg <= periph_wen_i ? rdata_mux : 32'h0;
         end
         start_reg <= trig_wr && !busy_reg;
         clear_reg <= clr_wr;
         if (clr_wr) begin
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
            done_cnt_reg <= '0;
         end else begin
            if (trig_wr && !busy_reg) busy_reg <= 1'b1;
            else if (job_done)        busy_reg <= 1'b0;
            if (trig_wr && busy_reg)  err_reg <= 1'b1;
            if (job_done)             done_cnt_reg <= done_cnt_reg + 32'd1;
         end
      end
   end

   assign periph_gnt_o     = grant;
   assign periph_r_valid_o = (state_reg == RESP);
   assign periph_r_data_o  = (state_reg == RESP) ? resp_data_reg : 32'h0;
   assign periph_r_id_o    = (state_reg == RESP) ? resp_id_reg : '0;
   assign start_o          = start_reg;
   assign clear_o          = clear_reg;
   assign busy_o           = busy_reg;

endmodule
